// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: front-end stall and flush control for a 5-stage pipeline.
// Handles three cases:
//   - taken-branch flush
//   - single-cycle load-use stall
//   - optional multi-cycle multiply freeze
// It also keeps a saturating count of front-end stall cycles.
// The multiply freeze is compiled in only when the macro MULDIV_STALL_EN is
// defined. Without it, id_is_mul is ignored, ex_hold is tied low and no
// multiply counter exists.
module hazard_stall_ctrl #(
    parameter int unsigned MUL_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_is_mul,
    input  logic [4:0]  ex_rt,
    input  logic        ex_mem_read,
    input  logic        branch_taken,
    output logic        if_id_write,
    output logic        pc_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        ex_hold,
    output logic [15:0] stall_cycles
);

    typedef enum logic {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic   load_use;
    logic   mul_issue;
    logic   mul_done;
    logic   hold_c;

    // A load in EX feeding a source register of the instruction in ID.
    // Register 0 is hard-wired, so it never creates a dependency.
    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

`ifdef MULDIV_STALL_EN
    localparam logic [3:0] MUL_LOAD = 4'(MUL_LATENCY - 1);

    logic [3:0] mul_cnt;

    // A multiply issues only when neither a branch flush nor a load-use stall
    // takes precedence in the same cycle.
    assign mul_issue = id_is_mul && !branch_taken && !load_use;
    assign mul_done  = (mul_cnt == 4'd1);
    assign ex_hold   = hold_c;

    // Remaining multiply occupancy: loaded on issue, counts down while busy
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_cnt <= 4'd0;
        end else if ((state == RUN) && mul_issue) begin
            mul_cnt <= MUL_LOAD;
        end else if (state == MUL_BUSY) begin
            mul_cnt <= mul_cnt - 4'd1;
        end
    end
`else
    logic unused_cfg;

    assign mul_issue  = 1'b0;
    assign mul_done   = 1'b1;
    assign ex_hold    = 1'b0;
    assign unused_cfg = ^{id_is_mul, hold_c, MUL_LATENCY[0]};
`endif

    // State register; reset always returns to RUN, aborting any multiply
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: enter MUL_BUSY on issue, leave on the last busy cycle
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      if (mul_issue) state_nxt = MUL_BUSY;
            MUL_BUSY: if (mul_done)  state_nxt = RUN;
        endcase
    end

    // Output decode.
    // Outputs are zero-latency and depend on state and current inputs.
    // A reset cycle forces the free-running defaults.
    always_comb begin
        if_id_write  = 1'b1;
        pc_write     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        hold_c       = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (load_use) begin
                        if_id_write  = 1'b0;
                        pc_write     = 1'b0;
                        id_ex_bubble = 1'b1;
                    end
                end
                MUL_BUSY: begin
                    if_id_write = 1'b0;
                    pc_write    = 1'b0;
                    hold_c      = 1'b1;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the front end was frozen
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 16'd0;
        end else if (!if_id_write && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 The block SHALL have parameter MUL_LATENCY, default 4, giving the EX-stage occupancy in cycles of a multi-cycle multiply; legal range 2..15.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 The block SHALL have ports id_rs and id_rt, input, 5 each, the source registers of the instruction in ID.
REQ-005 The block SHALL have port id_uses_rt, input, 1, which is high when the ID instruction reads rt.
REQ-006 The block SHALL have port id_is_mul, input, 1, which is high when the ID instruction is a multi-cycle multiply.
REQ-007 The block SHALL have ports ex_rt (input, 5) and ex_mem_read (input, 1), the destination and load flag of the instruction in EX.
REQ-008 The block SHALL have port branch_taken, input, 1, a taken branch resolved in EX this cycle.
REQ-009 The block SHALL have ports if_id_write and pc_write, output, 1 each, the write enables for the IF/ID register and PC.
REQ-010 The block SHALL have ports if_id_flush and id_ex_bubble, output, 1 each, which zero the IF/ID and ID/EX contents at the next edge.
REQ-011 The block SHALL have port ex_hold, output, 1, which holds the ID/EX and EX/MEM registers.
REQ-012 The block SHALL have port stall_cycles, output, 16, a performance counter of front-end stall cycles.

Function
REQ-013 FSM states SHALL be RUN and MUL_BUSY, with a 4-bit down-counter mul_cnt.
REQ-014 A load-use hazard SHALL be defined as ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
REQ-015 Outputs SHALL be combinational from state and current inputs, with zero-cycle detection latency.
REQ-016 In RUN, priority 1: if branch_taken, then if_id_flush=1, id_ex_bubble=1, pc_write=1, and if_id_write=1; the next state is RUN, and any hazard or id_is_mul is ignored.
REQ-017 In RUN, priority 2: on a load-use hazard, if_id_write=0, pc_write=0, id_ex_bubble=1; the next state is RUN, giving exactly one stall cycle per hazard instance.
REQ-018 In RUN, priority 3: on id_is_mul, all enables SHALL be 1 this cycle, the multiply issues, the next state is MUL_BUSY, and mul_cnt loads MUL_LATENCY-1.
REQ-019 In RUN otherwise: if_id_write=1, pc_write=1, and all other outputs are 0.
REQ-020 In MUL_BUSY: if_id_write=0, pc_write=0, ex_hold=1, id_ex_bubble=0, if_id_flush=0; mul_cnt decrements each cycle; when mul_cnt==1, the next state is RUN; total front-end freeze SHALL be MUL_LATENCY-1 cycles.
REQ-021 In MUL_BUSY, branch_taken, the hazard inputs, and id_is_mul SHALL be ignored.
REQ-022 A back-to-back multiply SHALL be detected in the first RUN cycle after MUL_BUSY and handled as in REQ-018.
REQ-023 stall_cycles SHALL increment on each edge where if_id_write==0, and saturate at 0xFFFF without wrap.

Reset
REQ-024 With rst high at an edge, the state SHALL be RUN, mul_cnt=0, and stall_cycles=0.
REQ-025 During a reset cycle, outputs SHALL be if_id_write=1, pc_write=1, and if_id_flush=id_ex_bubble=ex_hold=0.
REQ-026 rst asserted in MUL_BUSY SHALL abort the multiply stall immediately, and the first post-reset cycle SHALL be RUN.

Configuration
REQ-027 With macro MULDIV_STALL_EN defined, the MUL_BUSY path SHALL operate per REQ-018..REQ-022.
REQ-028 Without MULDIV_STALL_EN, id_is_mul SHALL be ignored, MUL_BUSY SHALL be unreachable, ex_hold SHALL be tied 0, mul_cnt SHALL not be instantiated, and the port list SHALL be unchanged.

Verification
REQ-029 Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 for one cycle -> if_id_write=0, pc_write=0, id_ex_bubble=1 for 1 cycle; stall_cycles 0->1.
REQ-030 Zero register and rt gating: ex_rt=0=id_rs, or ex_rt=id_rt=7 with id_uses_rt=0 -> no stall; stall_cycles unchanged.
REQ-031 Branch priority: branch_taken=1 together with a load-use hazard -> if_id_flush=1, id_ex_bubble=1, if_id_write=1, no stall.
REQ-032 Multiply: MUL_LATENCY=4, id_is_mul pulse -> 3 cycles with if_id_write=0 and ex_hold=1, then RUN; stall_cycles +=3; without MULDIV_STALL_EN -> no stall.
REQ-033 Reset mid-multiply: rst on the 2nd MUL_BUSY cycle -> next cycle RUN, if_id_write=1, ex_hold=0, stall_cycles=0.
REQ-034 Saturation: preload via 65535 stall cycles, then 3 more -> stall_cycles holds 0xFFFF.
